// File: rtl/kb_event_sched_pkg.sv
// Shared types and helpers for the keyboard event sequencer.
// A report is scanned as 14 slots: modifier bits 0..7, then key slots 1..6.
package kb_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SCAN_REL,
    SCAN_PRS,
    EMIT,
    GAP,
    COMMIT
  } state_t;

  localparam int         NUM_SLOTS    = 14;
  localparam logic [7:0] HID_NONE     = 8'h00;
  localparam logic [7:0] HID_ROLLOVER = 8'h01;
  localparam logic [7:0] HID_MOD_BASE = 8'hE0;

  // key[0] is slot 1, which sits in the top byte of the 48-bit key bus
  typedef struct packed {
    logic [7:0]      mod;
    logic [0:5][7:0] key;
  } kb_report_t;

  // HID usage carried by slot idx of report r (modifiers map to 0xE0..0xE7)
  function automatic logic [7:0] slot_code(kb_report_t r, logic [3:0] idx);
    logic [7:0] c;
    c = HID_NONE;
    if (idx < 4'd8) begin
      c = HID_MOD_BASE | {5'd0, idx[2:0]};
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (idx == 4'(k + 8)) c = r.key[k];
      end
    end
    return c;
  endfunction

  function automatic logic has_usage(kb_report_t r, logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (r.key[k] == code) hit = 1'b1;
    end
    return hit;
  endfunction

  // Slot idx is active in a and absent from b; a repeated usage only fires on its first slot
  function automatic logic slot_hit(kb_report_t a, kb_report_t b, logic [3:0] idx);
    logic       hit;
    logic [7:0] c;
    c   = slot_code(a, idx);
    hit = 1'b0;
    if (idx < 4'd8) begin
      hit = a.mod[idx[2:0]] & ~b.mod[idx[2:0]];
    end else if (idx < 4'(NUM_SLOTS) && c != HID_NONE && !has_usage(b, c)) begin
      hit = 1'b1;
      for (int j = 0; j < 6; j++) begin
        if (4'(j + 8) < idx && a.key[j] == c) hit = 1'b0;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/kb_event_sched_if.sv
// Event handshake between the sequencer (master) and the PS/2 translator (slave).
interface kb_event_sched_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_pressed;
  logic [7:0] ev_code;

  modport master (output ev_valid, output ev_pressed, output ev_code, input ev_ready);
  modport slave  (input ev_valid, input ev_pressed, input ev_code, output ev_ready);
endinterface

// File: rtl/kb_typematic.sv
// Typematic repeat timer: remembers the last non-modifier make and requests
// a repeat after TM_DELAY, then every TM_PERIOD. Built only with KB_TYPEMATIC_EN.
`ifdef KB_TYPEMATIC_EN
module kb_typematic
  import kb_sched_pkg::*;
#(
  parameter logic [23:0] TM_DELAY  = 24'd6_000_000,
  parameter logic [23:0] TM_PERIOD = 24'd1_200_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ev_done_i,
  input  logic       ev_pressed_i,
  input  logic [7:0] ev_code_i,
  input  logic       repeat_i,
  output logic       fire_o,
  output logic [7:0] code_o
);

  // Two cycles of the interval are spent reaching EMIT after the timer expires
  localparam logic [23:0] DLY_LOAD = (TM_DELAY  > 24'd1) ? TM_DELAY  - 24'd2 : 24'd0;
  localparam logic [23:0] PER_LOAD = (TM_PERIOD > 24'd1) ? TM_PERIOD - 24'd2 : 24'd0;

  logic        armed_q, armed_d;
  logic [7:0]  code_q, code_d;
  logic [23:0] cnt_q, cnt_d;

  // Arm/disarm on accepted events, otherwise count down to expiry
  always_comb begin
    armed_d = armed_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    if (ev_done_i && ev_pressed_i) begin
      if (ev_code_i >= HID_MOD_BASE) begin
        armed_d = 1'b0;
      end else begin
        armed_d = 1'b1;
        code_d  = ev_code_i;
        cnt_d   = repeat_i ? PER_LOAD : DLY_LOAD;
      end
    end else if (ev_done_i && armed_q && ev_code_i == code_q) begin
      armed_d = 1'b0;
    end else if (armed_q && cnt_q != 24'd0) begin
      cnt_d = cnt_q - 24'd1;
    end
  end

  // Timer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q <= 1'b0;
      code_q  <= 8'h00;
      cnt_q   <= 24'd0;
    end else begin
      armed_q <= armed_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fire_o = armed_q && (cnt_q == 24'd0);
  assign code_o = code_q;

endmodule
`endif

// File: rtl/kb_event_sched.sv
// Keyboard event sequencer: diffs each HID report against the last committed
// one and emits make/break events one at a time, spaced by GAP_CYCLES.
// Optional typematic repeat is enabled by defining KB_TYPEMATIC_EN.
//
// state    | meaning
// IDLE     | waiting for a report (pending or strobe) or a typematic repeat
// CAPTURE  | new report latched; drop it if it carries ErrorRollOver
// SCAN_REL | walk slots 0..13, old active & absent in new -> break
// SCAN_PRS | walk slots 0..13, new active & absent in old -> make
// EMIT     | ev_valid high, event held until accepted
// GAP      | enforced idle time after an accepted event
// COMMIT   | new report becomes the committed report
module kb_event_sched
  import kb_sched_pkg::*;
#(
  parameter logic [15:0] GAP_CYCLES = 16'd1000,
  parameter logic [23:0] TM_DELAY   = 24'd6_000_000,
  parameter logic [23:0] TM_PERIOD  = 24'd1_200_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             report_stb,
  input  logic [7:0]       usb_kb_mod,
  input  logic [47:0]      usb_kb_keys,
  kb_event_sched_if.master ev,
  output logic             busy,
  output logic [7:0]       ovf_cnt
);

  state_t     state_q, state_d, resume_q, resume_d;
  kb_report_t old_q, old_d, new_q, new_d, pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic [3:0] idx_q, idx_d;
  logic [15:0] gap_q, gap_d;
  logic [7:0] code_q, code_d, ovf_q, ovf_d;
  logic       pressed_q, pressed_d;

  kb_report_t in_rpt, scan_a, scan_b;
  logic       slot_evt, last_slot, hs;
  logic [7:0] slot_usage;
  state_t     nxt_state;
  logic [3:0] nxt_idx;

  assign in_rpt     = {usb_kb_mod, usb_kb_keys};
  assign scan_a     = (state_q == SCAN_PRS) ? new_q : old_q;
  assign scan_b     = (state_q == SCAN_PRS) ? old_q : new_q;
  assign slot_evt   = slot_hit(scan_a, scan_b, idx_q);
  assign slot_usage = slot_code(scan_a, idx_q);
  assign last_slot  = (idx_q == 4'(NUM_SLOTS - 1));
  assign nxt_state  = !last_slot ? state_q : ((state_q == SCAN_REL) ? SCAN_PRS : COMMIT);
  assign nxt_idx    = last_slot ? 4'd0 : idx_q + 4'd1;
  assign hs         = (state_q == EMIT) && ev.ev_ready;

`ifdef KB_TYPEMATIC_EN
  logic       tm_fire;
  logic [7:0] tm_code;

  kb_typematic #(
    .TM_DELAY  (TM_DELAY),
    .TM_PERIOD (TM_PERIOD)
  ) u_typematic (
    .clk          (clk),
    .reset_n      (reset_n),
    .ev_done_i    (hs),
    .ev_pressed_i (pressed_q),
    .ev_code_i    (code_q),
    .repeat_i     (resume_q == IDLE),
    .fire_o       (tm_fire),
    .code_o       (tm_code)
  );
`else
  logic unused_tm;
  assign unused_tm = ^{TM_DELAY, TM_PERIOD};
`endif

  // Next-state, scan walk and pending-report bookkeeping
  always_comb begin
    state_d    = state_q;
    resume_d   = resume_q;
    old_d      = old_q;
    new_d      = new_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    code_d     = code_q;
    pressed_d  = pressed_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (pend_vld_q) begin
          new_d      = pend_q;
          pend_vld_d = 1'b0;
          state_d    = CAPTURE;
        end else if (report_stb) begin
          new_d   = in_rpt;
          state_d = CAPTURE;
`ifdef KB_TYPEMATIC_EN
        end else if (tm_fire) begin
          code_d    = tm_code;
          pressed_d = 1'b1;
          resume_d  = IDLE;
          state_d   = EMIT;
`endif
        end
      end
      CAPTURE: begin
        idx_d   = 4'd0;
        state_d = has_usage(new_q, HID_ROLLOVER) ? IDLE : SCAN_REL;
      end
      SCAN_REL, SCAN_PRS: begin
        idx_d = nxt_idx;
        if (slot_evt) begin
          code_d    = slot_usage;
          pressed_d = (state_q == SCAN_PRS);
          resume_d  = nxt_state;
          state_d   = EMIT;
        end else begin
          state_d = nxt_state;
        end
      end
      EMIT: begin
        if (ev.ev_ready) begin
          if (GAP_CYCLES == 16'd0) begin
            state_d = resume_q;
          end else begin
            gap_d   = GAP_CYCLES - 16'd1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == 16'd0) state_d = resume_q;
        else                gap_d   = gap_q - 16'd1;
      end
      COMMIT: begin
        old_d   = new_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A strobe that cannot be taken directly lands in the 1-deep pending slot
    if (report_stb && (state_q != IDLE || pend_vld_q)) begin
      pend_d     = in_rpt;
      pend_vld_d = 1'b1;
      if (pend_vld_q && state_q != IDLE && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
    end
  end

  // Sequencer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      resume_q   <= IDLE;
      old_q      <= '0;
      new_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      idx_q      <= 4'd0;
      gap_q      <= 16'd0;
      code_q     <= 8'h00;
      pressed_q  <= 1'b0;
      ovf_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      resume_q   <= resume_d;
      old_q      <= old_d;
      new_q      <= new_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      code_q     <= code_d;
      pressed_q  <= pressed_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ev.ev_valid   = (state_q == EMIT);
  assign ev.ev_pressed = pressed_q;
  assign ev.ev_code    = code_q;
  assign busy          = (state_q != IDLE);
  assign ovf_cnt       = ovf_q;

endmodule

// File: tb/tb_kb_event_sched.sv
// Bench for kb_event_sched: directed scenarios plus random reports, with a
// report-level diff model feeding an expected-event queue and an
// independent monitor popping it on every accepted event.
module tb_kb_event_sched;

  localparam int GAP = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        report_stb = 1'b0;
  logic [7:0]  usb_kb_mod = 8'h00;
  logic [47:0] usb_kb_keys = 48'h0;
  logic        busy;
  logic [7:0]  ovf_cnt;

  kb_event_sched_if ev_if ();

  kb_event_sched #(.GAP_CYCLES(16'(GAP))) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .report_stb  (report_stb),
    .usb_kb_mod  (usb_kb_mod),
    .usb_kb_keys (usb_kb_keys),
    .ev          (ev_if),
    .busy        (busy),
    .ovf_cnt     (ovf_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic p; logic [7:0] c; } ev_t;
  ev_t        exp_q[$];
  logic [7:0] m_mod;
  logic [7:0] m_keys[6];

  function automatic bit in_keys(input logic [7:0] arr[6], input logic [7:0] c, input int upto);
    for (int k = 0; k < upto; k++) if (arr[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_ev(input logic p, input logic [7:0] c);
    ev_t e;
    e.p = p;
    e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic model_report(input logic [7:0] nm, input logic [47:0] nk);
    logic [7:0] nkeys[6];
    for (int k = 0; k < 6; k++) nkeys[k] = nk[47 - 8*k -: 8];
    if (in_keys(nkeys, 8'h01, 6)) return;
    for (int i = 0; i < 8; i++)
      if (m_mod[i] && !nm[i]) push_ev(1'b0, 8'(224 + i));
    for (int k = 0; k < 6; k++)
      if (m_keys[k] != 8'h00 && !in_keys(m_keys, m_keys[k], k) && !in_keys(nkeys, m_keys[k], 6))
        push_ev(1'b0, m_keys[k]);
    for (int i = 0; i < 8; i++)
      if (nm[i] && !m_mod[i]) push_ev(1'b1, 8'(224 + i));
    for (int k = 0; k < 6; k++)
      if (nkeys[k] != 8'h00 && !in_keys(nkeys, nkeys[k], k) && !in_keys(m_keys, nkeys[k], 6))
        push_ev(1'b1, nkeys[k]);
    m_mod  = nm;
    m_keys = nkeys;
  endtask

  task automatic model_reset();
    m_mod = 8'h00;
    for (int k = 0; k < 6; k++) m_keys[k] = 8'h00;
    exp_q.delete();
  endtask

  // ---------------- monitor ----------------
  int         since_hs = 0;
  bit         have_hs = 1'b0;
  bit         prev_wait = 1'b0;
  logic [8:0] prev_ev = 9'h0;
  ev_t        got;

  always @(negedge clk) begin
    if (!reset_n) begin
      have_hs   = 1'b0;
      prev_wait = 1'b0;
      since_hs  = 0;
    end else begin
      since_hs++;
      if (ev_if.ev_valid) begin
        if (prev_wait)
          chk("ev_stable", 32'({ev_if.ev_pressed, ev_if.ev_code}), 32'(prev_ev));
        else if (have_hs)
          chk("gap_min", 32'(since_hs > GAP), 32'd1);
        if (ev_if.ev_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_event: got pressed=%0b code=%0h expected none",
                     ev_if.ev_pressed, ev_if.ev_code);
          end else begin
            got = exp_q.pop_front();
            chk("ev_pressed", 32'(ev_if.ev_pressed), 32'(got.p));
            chk("ev_code", 32'(ev_if.ev_code), 32'(got.c));
          end
          have_hs   = 1'b1;
          since_hs  = 0;
          prev_wait = 1'b0;
        end else begin
          prev_wait = 1'b1;
          prev_ev   = {ev_if.ev_pressed, ev_if.ev_code};
        end
      end else begin
        if (prev_wait) chk("valid_held", 32'(ev_if.ev_valid), 32'd1);
        prev_wait = 1'b0;
      end
    end
  end

  // ---------------- ready randomiser ----------------
  bit rdy_rand = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rdy_rand) ev_if.ev_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] m, input logic [47:0] k, input bit use_model);
    usb_kb_mod  = m;
    usb_kb_keys = k;
    report_stb  = 1'b1;
    if (use_model) model_report(m, k);
    tick();
    report_stb = 1'b0;
  endtask

  task automatic wait_idle();
    int run = 0;
    int n = 0;
    while (run < 2 && n < 20000) begin
      tick();
      n++;
      run = busy ? 0 : run + 1;
    end
    chk("wait_idle", 32'(run >= 2), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!ev_if.ev_valid && n < 200) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(ev_if.ev_valid), 32'd1);
  endtask

  task automatic send_lat(input logic [7:0] m, input logic [47:0] k, input int exp_lat, input string name);
    int lat;
    send(m, k, 1'b1);
    lat = 1;
    while (!ev_if.ev_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk(name, 32'(lat), 32'(exp_lat));
  endtask

  // ---------------- main sequence ----------------
  logic [7:0]  r_mod;
  logic [47:0] r_keys;
  int          n_idle;

  initial begin
    ev_if.ev_ready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    chk("rst_ev_valid",   32'(ev_if.ev_valid), 32'd0);
    chk("rst_ev_pressed", 32'(ev_if.ev_pressed), 32'd0);
    chk("rst_ev_code",    32'(ev_if.ev_code), 32'd0);
    chk("rst_busy",       32'(busy), 32'd0);
    chk("rst_ovf",        32'(ovf_cnt), 32'd0);

    // single key make then break; make of slot 1 appears at cycle 25
    send_lat(8'h00, {8'h04, 40'h0}, 25, "make_latency");
    wait_idle();
    send(8'h00, 48'h0, 1'b1);
    wait_idle();
    chk("t1_drain", 32'(exp_q.size()), 32'd0);

    // earliest event: break of modifier bit 0 at cycle 3
    send(8'h01, 48'h0, 1'b1);
    wait_idle();
    send_lat(8'h00, 48'h0, 3, "break_latency");
    wait_idle();

    // ordering: break E1, break 04, make 06
    rdy_rand = 1'b1;
    send(8'h02, {8'h04, 8'h05, 32'h0}, 1'b1);
    wait_idle();
    send(8'h00, {8'h05, 8'h06, 32'h0}, 1'b1);
    wait_idle();
    chk("t2_drain", 32'(exp_q.size()), 32'd0);

    // ErrorRollOver in slot 3 drops the report; next diff is against {00,05 06}
    send(8'h00, {8'h05, 8'h07, 8'h01, 24'h0}, 1'b1);
    wait_idle();
    send(8'h10, {8'h07, 40'h0}, 1'b1);
    wait_idle();
    chk("t4_drain", 32'(exp_q.size()), 32'd0);

    // identical report: back in IDLE 31 cycles after the strobe
    send(8'h10, {8'h07, 40'h0}, 1'b1);
    n_idle = 1;
    while (busy && n_idle < 100) begin
      tick();
      n_idle++;
    end
    chk("ident_latency", 32'(n_idle), 32'd31);
    wait_idle();

    // backpressure plus three strobes while busy
    rdy_rand = 1'b0;
    ev_if.ev_ready = 1'b0;
    tick();
    send(8'h00, {8'h04, 40'h0}, 1'b1);
    wait_valid();
    for (int c = 0; c < 50; c++) begin
      if (c == 10) send(8'h00, {8'h0B, 40'h0}, 1'b0);
      else if (c == 20) send(8'h22, {8'h0C, 40'h0}, 1'b0);
      else if (c == 30) send(8'h00, {8'h04, 8'h08, 8'h09, 24'h0}, 1'b1);
      else tick();
    end
    chk("ovf_cnt_2", 32'(ovf_cnt), 32'd2);
    ev_if.ev_ready = 1'b1;
    wait_idle();
    chk("t3_drain", 32'(exp_q.size()), 32'd0);
    chk("ovf_cnt_hold", 32'(ovf_cnt), 32'd2);

    // reset while an event is presented
    ev_if.ev_ready = 1'b0;
    tick();
    send(8'h00, {8'h04, 8'h0A, 32'h0}, 1'b1);
    wait_valid();
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("reset_async_valid", 32'(ev_if.ev_valid), 32'd0);
    chk("reset_ovf", 32'(ovf_cnt), 32'd0);
    model_reset();
    tick();
    reset_n = 1'b1;
    ev_if.ev_ready = 1'b1;
    tick();
    send(8'h00, {8'h04, 40'h0}, 1'b1);
    wait_idle();
    chk("t5_drain", 32'(exp_q.size()), 32'd0);

    // random reports with random backpressure
    rdy_rand = 1'b1;
    r_mod  = 8'h00;
    r_keys = 48'h0;
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 4) != 0) begin
        r_mod = 8'($urandom & $urandom);
        for (int k = 0; k < 6; k++) begin
          int r;
          r = int'($urandom_range(0, 15));
          if (r < 6)
            r_keys[47 - 8*k -: 8] = 8'h00;
          else if (r == 6 && $urandom_range(0, 3) == 0)
            r_keys[47 - 8*k -: 8] = 8'h01;
          else
            r_keys[47 - 8*k -: 8] = 8'(4 + $urandom_range(0, 6));
        end
      end
      send(r_mod, r_keys, 1'b1);
      wait_idle();
    end
    rdy_rand = 1'b0;
    ev_if.ev_ready = 1'b1;
    repeat (4) tick();
    chk("final_drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
